// File: rtl/jogo_memoria_param_if.sv
// Player-facing signal bundle for the memory game: start/level request,
// buttons in, LEDs, result flags and debug taps out.
interface jogo_memoria_param_if #(
  parameter int N_BOTOES = 4,
  parameter int MAX_SEQ  = 16
);
  localparam int RW = $clog2(MAX_SEQ);
  localparam int BW = (N_BOTOES > 2) ? $clog2(N_BOTOES) : 1;

  logic                jogar;
  logic                nivel;
  logic [N_BOTOES-1:0] botoes;
  logic [N_BOTOES-1:0] leds;
  logic                ganhou;
  logic                perdeu;
  logic                timeout;
  logic                pronto;
  logic [3:0]          db_estado;
  logic [RW-1:0]       db_rodada;
  logic [BW-1:0]       db_esperado;

  modport master (
    output jogar, nivel, botoes,
    input  leds, ganhou, perdeu, timeout, pronto, db_estado, db_rodada, db_esperado
  );

  modport slave (
    input  jogar, nivel, botoes,
    output leds, ganhou, perdeu, timeout, pronto, db_estado, db_rodada, db_esperado
  );
endinterface

// File: rtl/jogo_memoria_param.sv
// Simon-style memory game: generates a random sequence, shows a growing prefix
// on the LEDs each round and checks the player's button presses against it.
module jogo_memoria_param #(
  parameter int N_BOTOES       = 4,
  parameter int MAX_SEQ        = 16,
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int LED_CICLOS     = 1000
) (
  input logic            clock,
  input logic            reset,
  jogo_memoria_param_if.slave io
);
  localparam int RW   = $clog2(MAX_SEQ);
  localparam int BW   = (N_BOTOES > 2) ? $clog2(N_BOTOES) : 1;
  localparam int TMAX = (TIMEOUT_CICLOS > LED_CICLOS) ? TIMEOUT_CICLOS : LED_CICLOS;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [3:0] INICIAL    = 4'h0;
  localparam logic [3:0] GERA       = 4'h1;
  localparam logic [3:0] MOSTRA     = 4'h2;
  localparam logic [3:0] APAGA      = 4'h3;
  localparam logic [3:0] ESPERA     = 4'h4;
  localparam logic [3:0] REGISTRA   = 4'h5;
  localparam logic [3:0] COMPARA    = 4'h6;
  localparam logic [3:0] PROXIMA    = 4'h7;
  localparam logic [3:0] FIM_RODADA = 4'h8;
  localparam logic [3:0] GANHOU     = 4'hA;
  localparam logic [3:0] TIMEOUT    = 4'hD;
  localparam logic [3:0] PERDEU     = 4'hE;

  localparam logic [TW-1:0] LED_FIM = TW'(LED_CICLOS - 1);
  localparam logic [TW-1:0] TMO_FIM = TW'(TIMEOUT_CICLOS - 1);
  localparam logic [RW-1:0] ULTIMO  = RW'(MAX_SEQ - 1);

  logic [3:0]          estado;
  logic [RW-1:0]       addr;
  logic [RW-1:0]       rodada;
  logic [TW-1:0]       tmr;
  logic                nivel_r;
  logic [N_BOTOES-1:0] jogada;
  logic [15:0]         lfsr;
  logic                botoes_d;
  logic [BW-1:0]       mem [MAX_SEQ];

  logic [BW-1:0]       esperado;
  logic [N_BOTOES-1:0] alvo;
  logic [BW-1:0]       sorteio;
  logic [RW-1:0]       len_m1;
  logic                jogou;
  logic                terminal;

  assign esperado = mem[addr];
  assign alvo     = N_BOTOES'(1) << esperado;
  assign sorteio  = BW'(lfsr[7:0] % 8'(N_BOTOES));
  assign len_m1   = nivel_r ? RW'(MAX_SEQ - 1) : RW'(MAX_SEQ / 2 - 1);
  // A play is the 0->1 edge of "any button"; holding keeps it from re-firing.
  assign jogou    = (|io.botoes) & ~botoes_d;
  assign terminal = (estado == GANHOU) || (estado == TIMEOUT) || (estado == PERDEU);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr     <= 16'hACE1;
      botoes_d <= 1'b0;
    end else begin
      lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      botoes_d <= |io.botoes;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_SEQ; i++) mem[i] <= '0;
    end else if (estado == GERA) begin
      mem[addr] <= sorteio;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado  <= INICIAL;
      addr    <= '0;
      rodada  <= '0;
      tmr     <= '0;
      nivel_r <= 1'b0;
      jogada  <= '0;
    end else begin
      case (estado)
        INICIAL, GANHOU, TIMEOUT, PERDEU: begin
          if (io.jogar) begin
            estado  <= GERA;
            nivel_r <= io.nivel;
            addr    <= '0;
            rodada  <= '0;
            tmr     <= '0;
          end
        end
        // The full MAX_SEQ table is always filled; nivel only limits rounds.
        GERA: begin
          if (addr == ULTIMO) begin
            addr   <= '0;
            estado <= MOSTRA;
          end else begin
            addr <= addr + RW'(1);
          end
        end
        MOSTRA: begin
          if (tmr == LED_FIM) begin
            tmr    <= '0;
            estado <= APAGA;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        APAGA: begin
          if (tmr == LED_FIM) begin
            tmr <= '0;
            if (addr < rodada) begin
              addr   <= addr + RW'(1);
              estado <= MOSTRA;
            end else begin
              addr   <= '0;
              estado <= ESPERA;
            end
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        ESPERA: begin
          if (jogou) begin
            jogada <= io.botoes;
            estado <= REGISTRA;
          end else if (tmr == TMO_FIM) begin
            estado <= TIMEOUT;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        REGISTRA: estado <= COMPARA;
        // Exact match against one-hot rejects multi-button presses too.
        COMPARA: begin
          if (jogada != alvo)       estado <= PERDEU;
          else if (addr < rodada)   estado <= PROXIMA;
          else                      estado <= FIM_RODADA;
        end
        PROXIMA: begin
          addr   <= addr + RW'(1);
          tmr    <= '0;
          estado <= ESPERA;
        end
        FIM_RODADA: begin
          if (rodada == len_m1) begin
            estado <= GANHOU;
          end else begin
            rodada <= rodada + RW'(1);
            addr   <= '0;
            tmr    <= '0;
            estado <= MOSTRA;
          end
        end
        default: estado <= INICIAL;
      endcase
    end
  end

  assign io.leds        = (estado == MOSTRA) ? alvo : '0;
  assign io.ganhou      = (estado == GANHOU);
  assign io.perdeu      = (estado == PERDEU);
  assign io.timeout     = (estado == TIMEOUT);
  assign io.pronto      = terminal;
  assign io.db_estado   = estado;
  assign io.db_rodada   = rodada;
  assign io.db_esperado = esperado;
endmodule
